pwm_shift_sched: RTL and testbench

PWM_SHIFT_SCHED -- requirements
Module: pwm_shift_sched

---
 rtl/pwm_sched_pkg.sv | 18 +
 rtl/pwm_shift_sched_duty_bank.sv | 76 +++++++
 rtl/pwm_shift_sched.sv | 151 +++++++++++++++
 tb/tb_pwm_shift_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_sched_pkg.sv
// pwm_sched_pkg -- shared types and default sizing for the PWM shift scheduler.
//   sched_state_t : scheduler FSM state encoding
//   CHANNELS_DEF  : default channel count serialized per step
//   PERIOD_DEF    : default number of steps per PWM period
//   DUTY_W_DEF    : default width of duty values and the step counter
package pwm_sched_pkg;

   localparam int CHANNELS_DEF = 8;
   localparam int PERIOD_DEF   = 100;
   localparam int DUTY_W_DEF   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } sched_state_t;

endpackage

// File: rtl/pwm_shift_sched_duty_bank.sv
// pwm_duty_bank -- per-channel duty registers and write decode.
// Optional feature macro: PWM_SCHED_SHADOW_EN (adds a pending bank that is
// copied to the active bank on commit).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   wr_en      : accepted write strobe
//   wr_ch      : target channel; channels >= CHANNELS are ignored
//   wr_duty    : duty value to write
//   commit     : end-of-period pulse (copies pending to active when shadowed)
//   duty_nxt   : active bank as it will be after this edge; the scheduler
//                snapshots it at a step start so that a same-edge write or
//                commit is already visible in that step
module pwm_duty_bank
#(
   parameter int  CHANNELS = 8,
   parameter int  DUTY_W   = 8,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             wr_en,
   input  logic [CH_W-1:0]                  wr_ch,
   input  logic [DUTY_W-1:0]                wr_duty,
   input  logic                             commit,
   output logic [CHANNELS-1:0][DUTY_W-1:0]  duty_nxt
);

   logic [CHANNELS-1:0][DUTY_W-1:0] active_q, active_d;
   logic                            hit;

   assign hit = wr_en && (32'(wr_ch) < 32'(CHANNELS));

`ifdef PWM_SCHED_SHADOW_EN
   logic [CHANNELS-1:0][DUTY_W-1:0] pending_q, pending_d;

   always_comb begin
      pending_d = pending_q;
      active_d  = active_q;
      if (hit)
         pending_d[wr_ch] = wr_duty;
      // pending_d already carries a same-cycle write, so a write landing on
      // the commit cycle reaches both banks.
      if (commit)
         active_d = pending_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
         active_q  <= '0;
      end else begin
         pending_q <= pending_d;
         active_q  <= active_d;
      end
   end
`else
   logic unused_commit;
   assign unused_commit = commit;

   always_comb begin
      active_d = active_q;
      if (hit)
         active_d[wr_ch] = wr_duty;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         active_q <= '0;
      else
         active_q <= active_d;
   end
`endif

   assign duty_nxt = active_d;

endmodule

// File: rtl/pwm_shift_sched.sv
// pwm_shift_sched -- serializes CHANNELS PWM bits per step into an external
// shift register, then latches them; PERIOD steps make one PWM period.
// Optional feature macro: PWM_SCHED_SHADOW_EN (duty writes are double
// buffered and take effect at the period boundary).
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   enable       : run request; low parks in IDLE after the current step
//   cfg_valid/cfg_ready, cfg_ch, cfg_duty : duty write handshake
//   s_data, s_shift : serial bit and its shift strobe
//   s_latch      : one-cycle output latch strobe
//   period_done  : one-cycle pulse in the latch cycle of step PERIOD-1
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | parked, outputs low, step counter held
// SHIFT | CHANNELS cycles shifting ch CHANNELS-1 down to ch0
// LATCH | one latch cycle, step advances, continue or park
module pwm_shift_sched
   import pwm_sched_pkg::*;
#(
   parameter int  CHANNELS = CHANNELS_DEF,
   parameter int  PERIOD   = PERIOD_DEF,
   parameter int  DUTY_W   = DUTY_W_DEF,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DUTY_W-1:0] cfg_duty,
   output logic              s_data,
   output logic              s_shift,
   output logic              s_latch,
   output logic              period_done
);

   sched_state_t                    state_q, state_d;
   logic [DUTY_W-1:0]               step_q, step_d, step_inc;
   logic [CH_W-1:0]                 idx_q, idx_d;
   logic [CHANNELS-1:0]             shreg_q, shreg_d;
   logic [CHANNELS-1:0]             cmp;
   logic                            s_data_q, s_data_d;
   logic                            s_shift_q, s_shift_d;
   logic                            s_latch_q, s_latch_d;
   logic                            period_done_q, period_done_d;
   logic                            cfg_ready_q;
   logic                            start_step;
   logic [CHANNELS-1:0][DUTY_W-1:0] duty_nxt;

   pwm_duty_bank #(
      .CHANNELS (CHANNELS),
      .DUTY_W   (DUTY_W)
   ) u_duty_bank (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (cfg_valid && cfg_ready_q),
      .wr_ch    (cfg_ch),
      .wr_duty  (cfg_duty),
      .commit   (period_done_q),
      .duty_nxt (duty_nxt)
   );

   assign step_inc = (step_q == DUTY_W'(PERIOD - 1)) ? '0 : step_q + DUTY_W'(1);
   assign step_d   = (state_q == LATCH) ? step_inc : step_q;

   // All channel compares are taken once at the step-start edge, so duty
   // writes during SHIFT/LATCH cannot disturb the step in flight.
   always_comb begin
      cmp = '0;
      for (int c = 0; c < CHANNELS; c++)
         cmp[c] = (step_d < duty_nxt[c]);
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      shreg_d       = shreg_q;
      s_data_d      = 1'b0;
      s_shift_d     = 1'b0;
      s_latch_d     = 1'b0;
      period_done_d = 1'b0;
      start_step    = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable)
               start_step = 1'b1;
         end
         SHIFT: begin
            if (idx_q == CH_W'(CHANNELS - 1)) begin
               state_d       = LATCH;
               idx_d         = '0;
               s_latch_d     = 1'b1;
               period_done_d = (step_q == DUTY_W'(PERIOD - 1));
            end else begin
               idx_d     = idx_q + CH_W'(1);
               s_shift_d = 1'b1;
               s_data_d  = shreg_q[CHANNELS-1];
               shreg_d   = shreg_q << 1;
            end
         end
         LATCH: begin
            if (enable)
               start_step = 1'b1;
            else
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // First shift bit goes out directly; the rest wait MSB-first in shreg.
      if (start_step) begin
         state_d   = SHIFT;
         idx_d     = '0;
         s_shift_d = 1'b1;
         s_data_d  = cmp[CHANNELS-1];
         shreg_d   = cmp << 1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         step_q        <= '0;
         idx_q         <= '0;
         shreg_q       <= '0;
         s_data_q      <= 1'b0;
         s_shift_q     <= 1'b0;
         s_latch_q     <= 1'b0;
         period_done_q <= 1'b0;
         cfg_ready_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         step_q        <= step_d;
         idx_q         <= idx_d;
         shreg_q       <= shreg_d;
         s_data_q      <= s_data_d;
         s_shift_q     <= s_shift_d;
         s_latch_q     <= s_latch_d;
         period_done_q <= period_done_d;
         cfg_ready_q   <= 1'b1;
      end
   end

   assign s_data      = s_data_q;
   assign s_shift     = s_shift_q;
   assign s_latch     = s_latch_q;
   assign period_done = period_done_q;
   assign cfg_ready   = cfg_ready_q;

endmodule

// File: tb/tb_pwm_shift_sched.sv
// Scoreboard bench for pwm_shift_sched: each step's expected serial stream is
// derived from a per-step duty model and queued; a negedge monitor pops and
// compares whenever the DUT strobes shift, latch or period_done.
module tb_pwm_shift_sched;
   import pwm_sched_pkg::*;

   localparam int CH  = CHANNELS_DEF;
   localparam int PER = PERIOD_DEF;

   logic       clk = 1'b0;
   logic       reset, enable, cfg_valid;
   logic [2:0] cfg_ch;
   logic [7:0] cfg_duty;
   logic       cfg_ready, s_data, s_shift, s_latch, period_done;

   pwm_shift_sched dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_ch      (cfg_ch),
      .cfg_duty    (cfg_duty),
      .s_data      (s_data),
      .s_shift     (s_shift),
      .s_latch     (s_latch),
      .period_done (period_done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          latch;
      bit          data;
      bit          pdone;
      int unsigned cyc;
      int          step;
      int          ch;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   int m_active [CH];
   int m_pend   [CH];
   int m_step;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d (cyc=%0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && (s_shift || s_latch || period_done)) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: shift=%0b latch=%0b pdone=%0b required=none (cyc=%0d)",
                     s_shift, s_latch, period_done, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("shift s%0d ch%0d", e.step, e.ch), int'(s_shift), int'(!e.latch));
            check($sformatf("latch s%0d", e.step), int'(s_latch), int'(e.latch));
            check($sformatf("data s%0d ch%0d", e.step, e.ch), int'(s_data), int'(e.data));
            check($sformatf("period_done s%0d", e.step), int'(period_done), int'(e.pdone));
            check($sformatf("timing s%0d ch%0d", e.step, e.ch), int'(cyc), int'(e.cyc));
         end
      end
   end

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_active[c] = 0;
         m_pend[c]   = 0;
      end
      m_step = 0;
   endtask

   task automatic model_write(input int ch, input int duty);
`ifdef PWM_SCHED_SHADOW_EN
      m_pend[ch] = duty;
`else
      m_active[ch] = duty;
`endif
   endtask

   // Called at the negedge just before the step-start edge.
   task automatic push_step();
      exp_t        e;
      int unsigned base;
      base = cyc + 1;
      for (int k = 0; k < CH; k++) begin
         e.latch = 1'b0;
         e.ch    = CH - 1 - k;
         e.data  = (m_step < m_active[CH-1-k]);
         e.pdone = 1'b0;
         e.cyc   = base + k;
         e.step  = m_step;
         exp_q.push_back(e);
      end
      e.latch = 1'b1;
      e.ch    = -1;
      e.data  = 1'b0;
      e.pdone = (m_step == PER - 1);
      e.cyc   = base + CH;
      e.step  = m_step;
      exp_q.push_back(e);
   endtask

   task automatic end_step();
`ifdef PWM_SCHED_SHADOW_EN
      if (m_step == PER - 1)
         for (int c = 0; c < CH; c++) m_active[c] = m_pend[c];
`endif
      m_step = (m_step + 1) % PER;
   endtask

   task automatic check_idle(input string name);
      check(name, int'({s_data, s_shift, s_latch, period_done}), 0);
   endtask

   // Precondition: at a negedge, next posedge starts a step.
   // Writes driven at negedge c (0..CH) land on an edge inside this step's
   // window and therefore belong to the next step.
   task automatic run_step(input bit do_write, input int wr_cycle, input int wch,
                           input int wduty, input bit drop, input int drop_cycle,
                           input int idle_n);
      push_step();
      @(posedge clk);
      for (int c = 0; c <= CH; c++) begin
         @(negedge clk);
         cfg_valid = do_write && (c == wr_cycle);
         cfg_ch    = 3'(wch);
         cfg_duty  = 8'(wduty);
         if (drop && c == drop_cycle) enable = 1'b0;
         if (c < CH) @(posedge clk);
      end
      if (do_write) model_write(wch, wduty);
      end_step();
      if (drop) begin
         for (int n = 0; n < idle_n; n++) begin
            @(posedge clk);
            @(negedge clk);
            cfg_valid = 1'b0;
            #1 check_idle("idle_after_drop");
         end
         enable = 1'b1;
      end
   endtask

   task automatic rand_step();
      bit do_w, drp;
      do_w = ($urandom_range(0, 3) == 0);
      drp  = ($urandom_range(0, 11) == 0);
      run_step(do_w, $urandom_range(0, CH), $urandom_range(0, CH - 1),
               $urandom_range(0, 255), drp, $urandom_range(0, CH), $urandom_range(1, 4));
   endtask

   // Precondition as run_step; reset hits during shift index 5.
   task automatic reset_mid_shift();
      push_step();
      @(posedge clk);
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         cfg_valid = 1'b0;
         if (c < 5) @(posedge clk);
      end
      #2 reset = 1'b1;
      exp_q.delete();
      #1;
      check_idle("outputs_at_reset");
      check("cfg_ready_at_reset", int'(cfg_ready), 0);
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   int init_duty [CH] = '{15, 25, 50, 20, 40, 75, 10, 80};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_duty  = '0;
      model_reset();

      repeat (3) @(negedge clk);
      #1;
      check("reset_s_data", int'(s_data), 0);
      check("reset_s_shift", int'(s_shift), 0);
      check("reset_s_latch", int'(s_latch), 0);
      check("reset_period_done", int'(period_done), 0);
      check("reset_cfg_ready", int'(cfg_ready), 0);

      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("cfg_ready_after_reset", int'(cfg_ready), 1);
      check_idle("idle_disabled");

      for (int c = 0; c < CH; c++) begin
         cfg_valid = 1'b1;
         cfg_ch    = 3'(c);
         cfg_duty  = 8'(init_duty[c]);
         model_write(c, init_duty[c]);
         @(negedge clk);
         check_idle("idle_during_cfg");
      end
      cfg_valid = 1'b0;
      enable    = 1'b1;

      // Period 1: fixed duties, ch2=90 written in step 40, enable drop at
      // shift index 3 of step 10.
      for (int s = 0; s < PER; s++)
         run_step(s == 40, $urandom_range(0, CH), 2, 90, s == 10, 3, 3);

      // Period 2: duty boundaries and a write on the period_done cycle.
      for (int s = 0; s < PER; s++) begin
         if (s == 5)       run_step(1'b1, $urandom_range(0, CH), 3, 0, 1'b0, 0, 1);
         else if (s == 6)  run_step(1'b1, $urandom_range(0, CH), 4, 120, 1'b0, 0, 1);
         else if (s == 99) run_step(1'b1, CH, 5, 33, 1'b0, 0, 1);
         else              run_step(1'b0, 0, 0, 0, 1'b0, 0, 1);
      end

      // Period 3: boundary duties stand; then randomized traffic.
      for (int s = 0; s < PER; s++)
         run_step(1'b0, 0, 0, 0, 1'b0, 0, 1);
      for (int s = 0; s < 80; s++)
         rand_step();

      reset_mid_shift();
      for (int s = 0; s < 5; s++)
         run_step(1'b0, 0, 0, 0, 1'b0, 0, 1);
      for (int s = 0; s < 30; s++)
         rand_step();
      run_step(1'b0, 0, 0, 0, 1'b0, 0, 1);

      enable = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      check_idle("final_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
